ia_capture_ctrl: RTL and testbench
==================================

IA_CAPTURE_CTRL -- requirements
Module: ia_capture_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_SKIP, default 0: number of frame-start pulses ignored between captures (0 = capture on every frame).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 840000: watchdog limit in clocks for one capture (two 800x525 frames).
REQ-003 The block SHALL have port i_clk, input, 1: single clock for all logic.
REQ-004 The block SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port i_enable, input, 1: continuous-capture request, level-sensitive.
REQ-006 The block SHALL have port i_single, input, 1: one-shot capture request, one-cycle pulse.
REQ-007 The block SHALL have port i_frame_start, input, 1: one-cycle pulse at the start of each camera frame.
REQ-008 The block SHALL have port o_itp_start, output, 1: one-cycle start pulse to the 128x128x3 interpolation/capture datapath.
REQ-009 The block SHALL have port i_itp_finish, input, 1: finish pulse from the interpolation datapath.
REQ-010 The block SHALL have port o_buf_valid, output, 1: the captured IA buffer is complete and owned by the consumer.
REQ-011 The block SHALL have port i_buf_ack, input, 1: consumer releases the buffer, one-cycle pulse.
REQ-012 The block SHALL have port o_busy, output, 1: high in every state except S_IDLE.
REQ-013 The block SHALL have port o_frame_cnt, output, 16: count of completed captures.
REQ-014 The block SHALL have port o_timeout, output, 1: sticky watchdog error flag.

Function
REQ-015 The FSM SHALL have states S_IDLE, S_WAIT_FRAME, S_START, S_RUN and S_HOLD; all outputs SHALL be registered.
REQ-016 From S_IDLE, i_enable=1 or i_single=1 SHALL move the FSM to S_WAIT_FRAME on the next clock; the skip counter SHALL clear.
REQ-017 In S_WAIT_FRAME, each i_frame_start SHALL either move to S_START, if skip counter == FRAME_SKIP (counter cleared), or increment the skip counter.
REQ-018 S_START SHALL last exactly one cycle, with o_itp_start=1 registered in the cycle after the triggering frame pulse, and then move to S_RUN.
REQ-019 In S_RUN, i_itp_finish SHALL move to S_HOLD, set o_buf_valid=1 in the next cycle and increment o_frame_cnt (wrap 0xFFFF->0); i_frame_start SHALL be ignored.
REQ-020 In S_HOLD, o_buf_valid SHALL stay 1 until i_buf_ack; on ack, o_buf_valid SHALL go to 0 and the FSM SHALL go to S_WAIT_FRAME if i_enable=1, else to S_IDLE.
REQ-021 i_buf_ack outside S_HOLD, i_itp_finish outside S_RUN, and i_single outside S_IDLE SHALL be ignored.
REQ-022 Deasserting i_enable in S_WAIT_FRAME SHALL return the FSM to S_IDLE unless the capture was armed by i_single; in S_START/S_RUN, the current capture SHALL complete.
REQ-023 i_itp_finish coincident with i_frame_start in S_RUN SHALL be treated as finish only; the frame pulse SHALL be dropped.

Reset
REQ-024 i_rst_n=0 SHALL asynchronously force S_IDLE, clear the skip, watchdog and frame counters, and drive o_itp_start=0, o_buf_valid=0, o_busy=0, o_frame_cnt=0 and o_timeout=0.
REQ-025 Reset mid-capture SHALL abandon the capture without a finish count; the first post-reset capture SHALL wait for a fresh i_frame_start.

Configuration
REQ-026 With IA_CAPTURE_TIMEOUT_EN defined, a 20-bit watchdog SHALL count cycles in S_START/S_RUN; at TIMEOUT_CYC it SHALL set o_timeout (cleared only by reset) and return the FSM to S_IDLE, with no o_buf_valid and no count increment.
REQ-027 Without IA_CAPTURE_TIMEOUT_EN, no watchdog logic SHALL exist, o_timeout SHALL be constant 0, and S_RUN SHALL wait indefinitely.

Verification
REQ-028 Single shot, FRAME_SKIP=0: i_single, then i_frame_start -> o_itp_start pulse 1 cycle; finish -> o_buf_valid=1 and o_frame_cnt=1; ack -> S_IDLE and o_busy=0.
REQ-029 Continuous, FRAME_SKIP=2: i_enable held, 9 frame pulses, immediate finish/ack -> exactly 3 o_itp_start pulses, on frame pulses 3, 6 and 9.
REQ-030 Frame pulses and acks during S_RUN -> no extra o_itp_start and o_buf_valid unaffected; finish+frame pulse in the same cycle -> S_HOLD and the frame is dropped.
REQ-031 Assert reset mid-S_RUN -> all outputs 0 the same cycle; a subsequent finish pulse -> o_frame_cnt stays 0.
REQ-032 With the macro, TIMEOUT_CYC=100 and no finish -> o_timeout=1 after 100 cycles, FSM in S_IDLE, o_frame_cnt unchanged.
REQ-033 Preload o_frame_cnt to 0xFFFF via 65535 fast captures, then one more capture -> o_frame_cnt=0.

Source files
------------

// File: rtl/ia_capture_ctrl.sv
// rtl/ia_capture_ctrl.sv - frame-synchronised capture sequencer for the IA interpolation datapath
// Define IA_CAPTURE_TIMEOUT_EN to build the 20-bit capture watchdog that drives o_timeout.
module ia_capture_ctrl #(
  parameter int FRAME_SKIP  = 0,
  parameter int TIMEOUT_CYC = 840000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_single,
  input  logic        i_frame_start,
  output logic        o_itp_start,
  input  logic        i_itp_finish,
  output logic        o_buf_valid,
  input  logic        i_buf_ack,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic        o_timeout
);

  localparam int SKIP_W = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(FRAME_SKIP);
  localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_START,
    S_RUN,
    S_HOLD
  } state_t;

  state_t            r_state;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic              r_single_arm;
  logic              w_done;
  logic              w_expire;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1048575) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 20-bit watchdog");
  end

  assign w_done = (r_state == S_RUN) && i_itp_finish;

`ifdef IA_CAPTURE_TIMEOUT_EN
  localparam logic [19:0] WDOG_LAST = 20'(TIMEOUT_CYC - 1);

  logic [19:0] r_wdog;
  logic        w_in_capture;

  assign w_in_capture = (r_state == S_START) || (r_state == S_RUN);
  // A finish arriving on the final watchdog cycle still completes the capture.
  assign w_expire     = w_in_capture && (r_wdog == WDOG_LAST) && !w_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog    <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (w_in_capture) begin
        r_wdog <= r_wdog + 20'd1;
      end else begin
        r_wdog <= '0;
      end
      if (w_expire) begin
        o_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_expire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_skip_cnt   <= '0;
      r_single_arm <= 1'b0;
      o_itp_start  <= 1'b0;
      o_buf_valid  <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      o_frame_cnt <= o_frame_cnt + 16'(w_done);
      case (r_state)
        S_IDLE: begin
          if (i_enable || i_single) begin
            r_state      <= S_WAIT_FRAME;
            r_skip_cnt   <= '0;
            r_single_arm <= i_single;
            o_busy       <= 1'b1;
          end
        end
        S_WAIT_FRAME: begin
          // A one-shot capture survives i_enable being low; continuous mode does not.
          if (!i_enable && !r_single_arm) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end else if (i_frame_start) begin
            if (r_skip_cnt == SKIP_LAST) begin
              r_state     <= S_START;
              r_skip_cnt  <= '0;
              o_itp_start <= 1'b1;
            end else begin
              r_skip_cnt <= r_skip_cnt + SKIP_ONE;
            end
          end
        end
        S_START: begin
          o_itp_start <= 1'b0;
          if (w_expire) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_done) begin
            r_state     <= S_HOLD;
            o_buf_valid <= 1'b1;
          end else if (w_expire) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (i_buf_ack) begin
            o_buf_valid  <= 1'b0;
            r_single_arm <= 1'b0;
            if (i_enable) begin
              r_state <= S_WAIT_FRAME;
            end else begin
              r_state <= S_IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          o_itp_start <= 1'b0;
          o_buf_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ia_capture_ctrl.sv
// tb/tb_ia_capture_ctrl.sv - self-checking bench for ia_capture_ctrl (FRAME_SKIP=0 and FRAME_SKIP=2 instances)
module tb_ia_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, sg, fs, fin, ack;
  logic        a_start, a_valid, a_busy, a_to;
  logic [15:0] a_cnt;
  logic        b_start, b_valid, b_busy, b_to;
  logic [15:0] b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ia_capture_ctrl #(.FRAME_SKIP(0), .TIMEOUT_CYC(100)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_single(sg), .i_frame_start(fs),
    .o_itp_start(a_start), .i_itp_finish(fin), .o_buf_valid(a_valid), .i_buf_ack(ack),
    .o_busy(a_busy), .o_frame_cnt(a_cnt), .o_timeout(a_to)
  );

  ia_capture_ctrl #(.FRAME_SKIP(2), .TIMEOUT_CYC(100)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_single(sg), .i_frame_start(fs),
    .o_itp_start(b_start), .i_itp_finish(fin), .o_buf_valid(b_valid), .i_buf_ack(ack),
    .o_busy(b_busy), .o_frame_cnt(b_cnt), .o_timeout(b_to)
  );

  typedef struct packed {
    logic [4:0]  in;   // en sg fs fin ack
    logic [2:0]  out;  // itp_start buf_valid busy
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic logic [19:0] snap_a();
    return {a_to, a_start, a_valid, a_busy, a_cnt};
  endfunction

  function automatic logic [19:0] snap_b();
    return {b_to, b_start, b_valid, b_busy, b_cnt};
  endfunction

  function automatic logic [19:0] expv(input logic to, input logic st, input logic vl,
                                       input logic bz, input logic [15:0] cnt);
    return {to, st, vl, bz, cnt};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got to/st/vl/bz/cnt=%b/%b/%b/%b/0x%04h required %b/%b/%b/%b/0x%04h",
               name, act[19], act[18], act[17], act[16], act[15:0],
               exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; sg = 1'b0; fs = 1'b0; fin = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    int starts;
    logic trig;

    //             en sg fs fin ack    st vl bz
    vecs[0]  = '{5'b00011, 3'b000, 16'd0};  // finish/ack in idle ignored
    vecs[1]  = '{5'b01000, 3'b001, 16'd0};  // single arms capture
    vecs[2]  = '{5'b00000, 3'b001, 16'd0};  // single-armed wait survives enable low
    vecs[3]  = '{5'b01100, 3'b101, 16'd0};  // frame -> start pulse
    vecs[4]  = '{5'b00101, 3'b001, 16'd0};  // pulse lasts one cycle; frame/ack ignored
    vecs[5]  = '{5'b00101, 3'b001, 16'd0};
    vecs[6]  = '{5'b00110, 3'b011, 16'd1};  // finish with frame: finish only
    vecs[7]  = '{5'b00100, 3'b011, 16'd1};  // hold keeps buffer
    vecs[8]  = '{5'b00001, 3'b000, 16'd1};  // ack, enable low -> idle
    vecs[9]  = '{5'b10000, 3'b001, 16'd1};
    vecs[10] = '{5'b00000, 3'b000, 16'd1};  // enable dropped while waiting
    vecs[11] = '{5'b10000, 3'b001, 16'd1};
    vecs[12] = '{5'b10100, 3'b101, 16'd1};
    vecs[13] = '{5'b10000, 3'b001, 16'd1};
    vecs[14] = '{5'b00000, 3'b001, 16'd1};  // enable dropped in run: capture continues
    vecs[15] = '{5'b00010, 3'b011, 16'd2};
    vecs[16] = '{5'b10001, 3'b001, 16'd2};  // ack with enable -> wait again
    vecs[17] = '{5'b10100, 3'b101, 16'd2};

    idle_inputs();
    rst_n = 1'b0;
    step();
    check("reset_a", snap_a(), expv(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    check("reset_b", snap_b(), expv(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    step();
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      {en, sg, fs, fin, ack} = vecs[i].in;
      step();
      check($sformatf("vec%0d", i), snap_a(),
            {1'b0, vecs[i].out[2], vecs[i].out[1], vecs[i].out[0], vecs[i].cnt});
    end

    // Reset asserted while dut_a is mid-capture with a non-zero count.
    idle_inputs();
    step();
    check("pre_reset_run", snap_a(), expv(1'b0, 1'b0, 1'b0, 1'b1, 16'd2));
    rst_n = 1'b0;
    #1;
    check("async_reset", snap_a(), expv(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    step();
    rst_n = 1'b1;
    fin = 1'b1;
    step();
    fin = 1'b0;
    check("finish_after_reset", snap_a(), expv(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    sg = 1'b1;
    step();
    sg = 1'b0;
    step();
    check("post_reset_waits", snap_a(), expv(1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    fs = 1'b1;
    step();
    fs = 1'b0;
    check("post_reset_fresh_frame", snap_a(), expv(1'b0, 1'b1, 0, 1'b1, 16'd0));

    // Continuous capture on dut_b, FRAME_SKIP=2.
    do_reset();
    en = 1'b1;
    step();
    c = 0;
    starts = 0;
    for (int k = 1; k <= 9; k++) begin
      fs = 1'b1;
      step();
      fs = 1'b0;
      trig = (k % 3 == 0);
      check($sformatf("cont_frame%0d", k), snap_b(), expv(1'b0, trig, 1'b0, 1'b1, 16'(c)));
      if (b_start) begin
        starts++;
        step();
        fin = 1'b1;
        step();
        fin = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        c++;
      end else begin
        step();
        step();
      end
    end
    check("cont_total", {4'd0, 16'(starts)}, {4'd0, 16'd3});
    check("cont_cnt", snap_b(), expv(1'b0, 1'b0, 1'b0, 1'b1, 16'd3));

    // Watchdog behaviour on dut_a.
    do_reset();
    sg = 1'b1;
    step();
    sg = 1'b0;
    fs = 1'b1;
    step();
    fs = 1'b0;
`ifdef IA_CAPTURE_TIMEOUT_EN
    repeat (99) step();
    check("wdog_before", snap_a(), expv(1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    step();
    check("wdog_expire", snap_a(), expv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    fin = 1'b1;
    step();
    fin = 1'b0;
    check("wdog_sticky", snap_a(), expv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
`else
    repeat (200) step();
    check("no_wdog_wait", snap_a(), expv(1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    fin = 1'b1;
    step();
    fin = 1'b0;
    check("no_wdog_finish", snap_a(), expv(1'b0, 1'b0, 1'b1, 1'b1, 16'd1));
`endif

    // Counter wrap: preload 0xFFFF, then one more capture.
    do_reset();
    force dut_a.o_frame_cnt = 16'hFFFF;
    step();
    release dut_a.o_frame_cnt;
    step();
    check("preload", snap_a(), expv(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF));
    sg = 1'b1;
    step();
    sg = 1'b0;
    fs = 1'b1;
    step();
    fs = 1'b0;
    step();
    fin = 1'b1;
    step();
    fin = 1'b0;
    check("wrap", snap_a(), expv(1'b0, 1'b0, 1'b1, 1'b1, 16'd0));
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("wrap_ack_idle", snap_a(), expv(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
